// File: rtl/totient_seq_engine.sv
// Iterative Euler-totient engine: counts k in 1..n coprime to n using subtractive Euclid.
// Optional macro TOTIENT_PRIME_FLAG_EN adds the is_prime output.
module totient_seq_engine #(
    parameter int WIDTH = 5
) (
    input  logic             clk_0,
    input  logic             R,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] phi_out,
`ifdef TOTIENT_PRIME_FLAG_EN
    output logic             is_prime,
`endif
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GCD,
        CHECK,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] n, k, a, b, cnt;
    logic [WIDTH-1:0] cnt_inc;

    // Count value including the current CHECK's contribution, so phi_out is valid during done.
    assign cnt_inc = (a == WIDTH'(1)) ? cnt + WIDTH'(1) : cnt;

    always_ff @(posedge clk_0) begin
        if (R) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (n_in == '0) ? DONE : LOAD;
                end
            end
            LOAD:  state_next = GCD;
            GCD: begin
                if (a == b) begin
                    state_next = CHECK;
                end
            end
            CHECK: state_next = (k == n) ? DONE : LOAD;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (R) begin
            n        <= '0;
            k        <= '0;
            a        <= '0;
            b        <= '0;
            cnt      <= '0;
            phi_out  <= '0;
            err      <= 1'b0;
`ifdef TOTIENT_PRIME_FLAG_EN
            is_prime <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        if (n_in != '0) begin
                            n   <= n_in;
                            k   <= WIDTH'(1);
                            err <= 1'b0;
                        end else begin
                            err      <= 1'b1;
                            phi_out  <= '0;
`ifdef TOTIENT_PRIME_FLAG_EN
                            is_prime <= 1'b0;
`endif
                        end
                    end
                end
                LOAD: begin
                    a <= n;
                    b <= k;
                end
                GCD: begin
                    if (a > b) begin
                        a <= a - b;
                    end else if (a < b) begin
                        b <= b - a;
                    end
                end
                CHECK: begin
                    cnt <= cnt_inc;
                    // k is compared before incrementing, so it never passes n and never wraps.
                    if (k == n) begin
                        phi_out  <= cnt_inc;
`ifdef TOTIENT_PRIME_FLAG_EN
                        is_prime <= (n >= WIDTH'(2)) && (cnt_inc == n - WIDTH'(1));
`endif
                    end else begin
                        k <= k + WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_totient_seq_engine.sv
// Directed self-checking bench for totient_seq_engine with hand-computed phi values.
module tb_totient_seq_engine;

    localparam int WIDTH = 5;

    logic             clk_0 = 1'b0;
    logic             R;
    logic             start;
    logic [WIDTH-1:0] n_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] phi_out;
    logic             err;
`ifdef TOTIENT_PRIME_FLAG_EN
    logic             is_prime;
`endif

    int checks = 0;
    int passed = 0;

    totient_seq_engine #(.WIDTH(WIDTH)) dut (
        .clk_0   (clk_0),
        .R       (R),
        .start   (start),
        .n_in    (n_in),
        .busy    (busy),
        .done    (done),
        .phi_out (phi_out),
`ifdef TOTIENT_PRIME_FLAG_EN
        .is_prime(is_prime),
`endif
        .err     (err)
    );

    always #5 clk_0 = ~clk_0;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Issues one start pulse and returns the number of edges until done is seen (edge 1 samples start).
    task automatic applyStimulus(input logic [WIDTH-1:0] val, output int edges);
        @(negedge clk_0);
        start = 1'b1;
        n_in  = val;
        edges = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk_0);
            edges++;
            @(negedge clk_0);
            start = 1'b0;
            n_in  = ~val;
            if (done) return;
        end
        checkOutput("done_timeout", int'(done), 1);
    endtask

    int exp_phi[16] = '{1, 1, 2, 2, 4, 2, 6, 4, 6, 4, 10, 4, 12, 6, 8, 8};

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int edges;
        int dones;

        R     = 1'b1;
        start = 1'b0;
        n_in  = '0;
        repeat (2) @(posedge clk_0);
        @(negedge clk_0);
        R = 1'b0;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_phi", int'(phi_out), 0);
        checkOutput("rst_err", int'(err), 0);

        applyStimulus(5'd1, edges);
        checkOutput("lat_n1", edges, 4);
        checkOutput("phi_n1", int'(phi_out), 1);

        applyStimulus(5'd2, edges);
        checkOutput("lat_n2", edges, 8);
        checkOutput("phi_n2", int'(phi_out), 1);
        @(negedge clk_0);
        checkOutput("done_width", int'(done), 0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(WIDTH'(i + 1), edges);
            checkOutput($sformatf("sweep_phi_%0d", i + 1), int'(phi_out), exp_phi[i]);
        end

        applyStimulus(5'd31, edges);
        checkOutput("phi_n31", int'(phi_out), 30);

        applyStimulus(5'd0, edges);
        checkOutput("lat_n0", edges, 1);
        checkOutput("phi_n0", int'(phi_out), 0);
        checkOutput("err_n0", int'(err), 1);

        applyStimulus(5'd7, edges);
        checkOutput("err_cleared", int'(err), 0);
        checkOutput("phi_n7", int'(phi_out), 6);

        // Hammer start with a different operand while the engine is busy.
        @(negedge clk_0);
        start = 1'b1;
        n_in  = 5'd12;
        dones = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_0);
            @(negedge clk_0);
            if (done) begin
                dones++;
                start = 1'b0;
                break;
            end
            start = 1'b1;
            n_in  = 5'd9;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_0);
            if (done) dones++;
        end
        checkOutput("busy_start_dones", dones, 1);
        checkOutput("busy_start_phi", int'(phi_out), 4);

        @(negedge clk_0);
        start = 1'b1;
        n_in  = 5'd15;
        @(negedge clk_0);
        start = 1'b0;
        repeat (20) @(negedge clk_0);
        checkOutput("midrun_busy", int'(busy), 1);
        R = 1'b1;
        @(negedge clk_0);
        R = 1'b0;
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_done", int'(done), 0);
        checkOutput("midrst_phi", int'(phi_out), 0);
        checkOutput("midrst_err", int'(err), 0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_0);
            if (done) dones++;
        end
        checkOutput("midrst_no_done", dones, 0);

        applyStimulus(5'd15, edges);
        checkOutput("phi_n15_restart", int'(phi_out), 8);

`ifdef TOTIENT_PRIME_FLAG_EN
        applyStimulus(5'd13, edges);
        checkOutput("phi_n13", int'(phi_out), 12);
        checkOutput("prime_n13", int'(is_prime), 1);
        applyStimulus(5'd9, edges);
        checkOutput("prime_n9", int'(is_prime), 0);
        applyStimulus(5'd1, edges);
        checkOutput("prime_n1", int'(is_prime), 0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
